// File: rtl/timer_pkg.sv
// Shared definitions for the down counter/timer.
// - state_t        : controller state encoding (IDLE/RUN/DONE)
// - DEF_DATA_SIZE  : default count width
// - DEF_PRESCALE_W : default prescaler width (only used with TIMER_PRESCALE_EN)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_DATA_SIZE  = 4;
  localparam int DEF_PRESCALE_W = 2;

endpackage

// File: rtl/tick_prescaler.sv
// Step-strobe generator for the down counter/timer.
// The internal counter advances on each enabled cycle. The step strobe is high
// on the enabled cycle where the counter is all-ones, so one step is produced
// every 2^W enabled cycles. The down counter only instantiates this block
// when TIMER_PRESCALE_EN is defined.
// Ports:
//   clk     : system clock
//   reset_n : async active-low reset, clears the count
//   clr     : synchronous clear (load restarts the prescale phase)
//   cnt_en  : count this cycle (enabled RUN cycle)
//   step    : strobe, cnt_en && count all-ones
module tick_prescaler #(
  parameter int W = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic cnt_en,
  output logic step
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (cnt_en) cnt <= cnt + W'(1);
  end

  assign step = cnt_en && (&cnt);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable, enable-gated down counter/timer with terminal-count pulse and
// optional auto-reload.
// Optional feature: TIMER_PRESCALE_EN -- when defined, count steps happen only
// once every 2^PRESCALE_W enabled RUN cycles (see tick_prescaler).
// Ports:
//   clk         : system clock
//   reset_n     : async active-low reset
//   load        : load strobe (highest priority), starts a run
//   load_val    : start/reload value captured on load
//   en          : count enable, low holds the count
//   auto_reload : 1 = reload and keep running at zero, 0 = stop at zero
//   q_out       : current count (registered)
//   tc          : terminal-count pulse, one clk wide (registered)
//   busy        : high while in RUN
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_val,
  input  logic                 en,
  input  logic                 auto_reload,
  output logic [DATA_SIZE-1:0] q_out,
  output logic                 tc,
  output logic                 busy
);

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] q_nxt, reload_reg, reload_nxt;
  logic                 tc_nxt;
  logic                 step;

`ifdef TIMER_PRESCALE_EN
  // Prescaler only advances on enabled RUN cycles that are not overridden
  // by a load; load also restarts its phase.
  tick_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (load),
    .cnt_en  ((state == RUN) && en && !load),
    .step    (step)
  );
`else
  assign step = en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      q_out      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_nxt;
      q_out      <= q_nxt;
      reload_reg <= reload_nxt;
      tc         <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q_out;
    reload_nxt = reload_reg;
    tc_nxt     = 1'b0;
    if (load) begin
      q_nxt      = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : DONE;
    end else begin
      case (state)
        RUN: begin
          if (en && step) begin
            if (q_out > DATA_SIZE'(1)) begin
              q_nxt = q_out - DATA_SIZE'(1);
            end else if (q_out == DATA_SIZE'(1)) begin
              // tc lands in the same edge as q_out -> 0
              q_nxt  = '0;
              tc_nxt = 1'b1;
              if (!auto_reload) state_nxt = DONE;
            end else begin
              // zero while still RUN only happens on the reload path
              q_nxt = reload_reg;
            end
          end
        end
        IDLE, DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // decoded from the state register only
  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int DW = 4;
  localparam int PW = 2;
`ifdef TIMER_PRESCALE_EN
  localparam int DIV = 1 << PW;
`else
  localparam int DIV = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [DW-1:0] load_val;
  logic          en;
  logic          auto_reload;
  logic [DW-1:0] q_out;
  logic          tc;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: remaining count, stored period value, running flag,
  // number of enabled running cycles since the last load
  int m_q, m_reload, m_en_cycles;
  bit m_running, m_tc;

  down_counter_timer #(.DATA_SIZE(DW), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q_out       (q_out),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q = 0; m_reload = 0; m_en_cycles = 0; m_running = 0; m_tc = 0;
  endtask

  // one rising edge of the timer, from the written rules
  task automatic model_edge();
    m_tc = 0;
    if (load) begin
      m_q = int'(load_val);
      m_reload = int'(load_val);
      m_running = (load_val != 0);
      m_en_cycles = 0;
    end else if (m_running && en) begin
      m_en_cycles++;
      if (m_en_cycles % DIV == 0) begin
        if (m_q == 0) m_q = m_reload;
        else begin
          m_q = m_q - 1;
          if (m_q == 0) begin
            m_tc = 1;
            m_running = auto_reload;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (q_out === DW'(m_q)) else begin
      n_err++; $error("FAIL %s q_out: got %0d want %0d", tag, q_out, m_q);
    end
    n_cmp++;
    assert (tc === m_tc) else begin
      n_err++; $error("FAIL %s tc: got %0b want %0b", tag, tc, m_tc);
    end
    n_cmp++;
    assert (busy === m_running) else begin
      n_err++; $error("FAIL %s busy: got %0b want %0b", tag, busy, m_running);
    end
  endtask

  // inputs are changed only around the falling edge
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  task automatic do_load(input int v, input string tag);
    load = 1'b1; load_val = DW'(v);
    tick(tag);
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_state");
    reset_n = 1'b1;

    // count 5 down, no reload, then hold at zero
    en = 1'b1;
    do_load(5, "load5");
    for (int i = 0; i < 5 * DIV; i++) tick("down5");
    n_cmp++;
    assert (q_out === '0 && tc === 1'b1 && busy === 1'b0) else begin
      n_err++; $error("FAIL down5_end: got q=%0d tc=%0b busy=%0b want 0/1/0", q_out, tc, busy);
    end
    for (int i = 0; i < 10; i++) tick("hold_zero");

    // async reset mid-run, no clock edge
    do_load(7, "load7");
    tick("run7");
    #2 reset_n = 1'b0;
    model_reset();
    #1 check("async_reset");
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick("idle_en_no_load");

    // periodic auto-reload
    auto_reload = 1'b1;
    do_load(3, "load3_ar");
    for (int i = 0; i < 12 * DIV; i++) tick("auto_reload");
    auto_reload = 1'b0;

    // enable dropped while q_out == 2
    do_load(4, "load4");
    for (int i = 0; i < 2 * DIV; i++) tick("to_two");
    en = 1'b0;
    for (int i = 0; i < 3; i++) tick("en_hold");
    n_cmp++;
    assert (q_out === DW'(2) && tc === 1'b0) else begin
      n_err++; $error("FAIL en_hold_val: got q=%0d tc=%0b want 2/0", q_out, tc);
    end
    en = 1'b1;
    for (int i = 0; i < 2 * DIV; i++) tick("en_resume");

    // load while at the terminal step wins over tc
    do_load(2, "load2");
    while (m_q != 1) tick("to_one");
    for (int i = 0; i < DIV - 1; i++) tick("to_term");
    do_load(9, "load_over_tc");
    n_cmp++;
    assert (q_out === DW'(9) && tc === 1'b0 && busy === 1'b1) else begin
      n_err++; $error("FAIL load_over_tc_val: got q=%0d tc=%0b busy=%0b want 9/0/1", q_out, tc, busy);
    end
    do_load(0, "load_zero");
    tick("after_load_zero");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      load        = ($urandom_range(0, 9) == 0);
      load_val    = DW'($urandom);
      en          = ($urandom_range(0, 3) != 0);
      auto_reload = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset_n = 1'b0;
        model_reset();
        #1 check("rand_async_reset");
        #1 reset_n = 1'b1;
      end
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable, enable-gated down counter/timer, the count-down counterpart of the team's 4-bit up counter. Software/FSM loads a start value; the block counts down to zero, flags terminal count, and optionally auto-reloads for periodic ticks. It sits beside the up counter as the team's generic interval/timeout source.

Parameters:
DATA_SIZE, 4, width of count, load value and reload register
PRESCALE_W, 2, prescaler width; used only when TIMER_PRESCALE_EN is defined

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
load  input  1  load strobe; loads load_val and starts a run
load_val  input  DATA_SIZE  start/reload value captured on load
en  input  1  count enable; low holds current count
auto_reload  input  1  1: reload and keep running at zero; 0: stop at zero
q_out  output  DATA_SIZE  current count, registered
tc  output  1  terminal-count pulse, registered, one clk wide
busy  output  1  high while state == RUN

Behaviour:
- One clock (clk); reset_n asynchronous, active-low. Assertion immediately clears, no clock edge needed: q_out=0, reload_reg=0, tc=0, busy=0, state=IDLE. Deassertion takes effect at next rising edge.
- States: IDLE (after reset, q_out=0), RUN (counting), DONE (reached zero, no reload).
- load=1 in any state, highest priority: q_out<=load_val, reload_reg<=load_val, tc<=0; next state RUN if load_val!=0, else DONE with no tc.
- RUN, en=1, q_out>1: q_out<=q_out-1.
- RUN, en=1, q_out==1: q_out<=0, tc<=1 in the same edge, so tc is high exactly in the cycle q_out reads 0. auto_reload sampled at this edge: 1 -> stay RUN; 0 -> DONE.
- RUN, en=1, q_out==0 (only reachable after reload path): q_out<=reload_reg, tc<=0. Period with auto_reload = reload_reg+1 enabled cycles.
- RUN, en=0: q_out, state held; tc<=0.
- IDLE/DONE without load: q_out held (0), tc=0, en ignored.
- No underflow: q_out never wraps from 0 to all-ones; reload is the only 0->nonzero path besides load.
- tc is 0 in every cycle not described above.
- load coincident with terminal condition: load wins, tc stays 0.
- Reset mid-run: async clear as above; pending tc lost.
- busy registered-equivalent: decoded from state register, no combinational path from inputs.

Optional Feature:
Macro TIMER_PRESCALE_EN.
- Defined: internal PRESCALE_W-bit prescaler counts enabled RUN cycles; q_out decrement/reload steps occur only on cycles where the prescaler is all-ones (once every 2^PRESCALE_W enabled cycles). Prescaler cleared on reset and on load; held when en=0. tc still one clk wide.
- Undefined: no prescaler logic; every enabled RUN cycle is a step.

Decomposition:
- Package timer_pkg: state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10; default DATA_SIZE and PRESCALE_W constants.
- Sub-module tick_prescaler (step-strobe generator, instantiated only under TIMER_PRESCALE_EN); remaining logic in one module.

Test Plan:
- reset_n=0 mid-simulation, no clock edge -> q_out=0, tc=0, busy=0 immediately; then en=1 with no load for 5 cycles -> q_out stays 0, busy=0.
- load_val=5, en=1, auto_reload=0 -> q_out 5,4,3,2,1,0 on successive edges; tc=1 only in the q_out=0 cycle; busy falls with it; q_out holds 0 for 10 more cycles.
- load_val=3, en=1, auto_reload=1 -> q_out 3,2,1,0,3,2,1,0,3; tc pulses every 4 cycles; busy stays 1.
- load_val=4, drop en for 3 cycles when q_out=2 -> q_out holds 2, no tc; re-raise en -> 1,0 with tc.
- Counting with q_out=1, en=1, load=1 with load_val=9 -> next q_out=9, tc stays 0, state RUN; load_val=0 -> q_out=0, DONE, busy=0, no tc.
- TIMER_PRESCALE_EN defined, PRESCALE_W=2, load_val=2, en=1 -> q_out changes every 4 cycles (2,1,0); tc one cycle wide.
